// File: rtl/cpu_accel_pkg.sv
// Shared widths, payload types and helpers for the CPU accelerator endpoint.
// Optional error reporting is enabled with CPU_ACCEL_ENDPOINT_ERR_EN.
package cpu_accel_pkg;

    localparam int unsigned DATA_WIDTH      = 16;
    localparam int unsigned ID_WIDTH        = 4;
    localparam int unsigned ERR_COUNT_WIDTH = 8;

    typedef logic [DATA_WIDTH-1:0]      accel_word_t;
    typedef logic [ID_WIDTH-1:0]        accel_id_t;
    typedef logic [ERR_COUNT_WIDTH-1:0] err_count_t;

    // Saturating increment for the illegal-access counter
    function automatic err_count_t err_count_inc(input err_count_t value);
        if (value == '1) begin
            return value;
        end
        return value + ERR_COUNT_WIDTH'(1);
    endfunction

endpackage : cpu_accel_pkg

// File: rtl/cpu_accel_fifo.sv
// Synchronous first-word-fall-through FIFO. DEPTH must be a power of two >= 2;
// pointers wrap naturally modulo DEPTH. Push on full / pop on empty are dropped.
module cpu_accel_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [WIDTH-1:0]         o_head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    // Storage array; contents need no reset since the count qualifies the head
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointer and occupancy tracking; simultaneous push+pop keeps the count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : cpu_accel_fifo

// File: rtl/cpu_accel_endpoint.sv
// Accelerator-side responder for the CPU accelerator port. Decodes accel_id,
// queues CPU writes toward the core and core results back toward the CPU.
// A deselected instance drives zeros so instances can be OR-combined.
// Optional macro CPU_ACCEL_ENDPOINT_ERR_EN adds sticky err and a saturating
// err_count for illegal accesses made while selected.
module cpu_accel_endpoint #(
    parameter int unsigned DATA_WIDTH = cpu_accel_pkg::DATA_WIDTH,
    parameter int unsigned ID_WIDTH   = cpu_accel_pkg::ID_WIDTH,
    parameter int unsigned ACCEL_ID   = 0,
    parameter int unsigned CMD_DEPTH  = 4,
    parameter int unsigned RSP_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   accel_id,
    output logic                  accel_can_read,
    output logic                  accel_can_write,
    input  logic                  accel_read_enable,
    output logic [DATA_WIDTH-1:0] accel_read_data,
    input  logic                  accel_write_enable,
    input  logic [DATA_WIDTH-1:0] accel_write_data,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [DATA_WIDTH-1:0] cmd_data,
    input  logic                  rsp_valid,
    output logic                  rsp_ready,
    input  logic [DATA_WIDTH-1:0] rsp_data
`ifdef CPU_ACCEL_ENDPOINT_ERR_EN
    ,
    output logic                  err,
    output logic [7:0]            err_count
`endif
);

    import cpu_accel_pkg::*;

    localparam int unsigned CMD_CW = $clog2(CMD_DEPTH) + 1;
    localparam int unsigned RSP_CW = $clog2(RSP_DEPTH) + 1;

    logic                  w_sel;
    logic                  w_cmd_push;
    logic                  w_cmd_pop;
    logic                  w_cmd_full;
    logic                  w_cmd_empty;
    logic [CMD_CW-1:0]     w_cmd_count;
    logic [DATA_WIDTH-1:0] w_cmd_head;
    logic                  w_rsp_push;
    logic                  w_rsp_pop;
    logic                  w_rsp_full;
    logic                  w_rsp_empty;
    logic [RSP_CW-1:0]     w_rsp_count;
    logic [DATA_WIDTH-1:0] w_rsp_head;

    // Address decode: only the current-cycle id gates CPU-side handshakes
    assign w_sel = (accel_id == ID_WIDTH'(ACCEL_ID));

    // CPU-facing status and data, forced to zero when deselected
    always_comb begin
        accel_can_write = 1'b0;
        accel_can_read  = 1'b0;
        accel_read_data = '0;
        if (w_sel) begin
            accel_can_write = !w_cmd_full;
            accel_can_read  = !w_rsp_empty;
            if (!w_rsp_empty) begin
                accel_read_data = w_rsp_head;
            end
        end
    end

    // Core-facing handshake; cmd_data is held at zero while nothing is queued
    always_comb begin
        cmd_valid = !w_cmd_empty;
        cmd_data  = '0;
        rsp_ready = !w_rsp_full;
        if (!w_cmd_empty) begin
            cmd_data = w_cmd_head;
        end
    end

    assign w_cmd_push = accel_write_enable && accel_can_write;
    assign w_cmd_pop  = cmd_valid && cmd_ready;
    assign w_rsp_push = rsp_valid && rsp_ready;
    assign w_rsp_pop  = accel_read_enable && accel_can_read;

    cpu_accel_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_cmd_push),
        .i_push_data (accel_write_data),
        .i_pop       (w_cmd_pop),
        .o_full      (w_cmd_full),
        .o_empty     (w_cmd_empty),
        .o_count     (w_cmd_count),
        .o_head      (w_cmd_head)
    );

    cpu_accel_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_rsp_push),
        .i_push_data (rsp_data),
        .i_pop       (w_rsp_pop),
        .o_full      (w_rsp_full),
        .o_empty     (w_rsp_empty),
        .o_count     (w_rsp_count),
        .o_head      (w_rsp_head)
    );

    // Occupancy sanity: counts never exceed their depth
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (w_cmd_count <= CMD_CW'(CMD_DEPTH))
                else $error("cmd fifo count out of range");
            assert (w_rsp_count <= RSP_CW'(RSP_DEPTH))
                else $error("rsp fifo count out of range");
        end
    end

`ifdef CPU_ACCEL_ENDPOINT_ERR_EN
    logic       w_illegal;
    logic       r_err;
    err_count_t r_err_count;

    assign w_illegal = w_sel && ((accel_read_enable && w_rsp_empty) ||
                                 (accel_write_enable && w_cmd_full));

    // Sticky error flag and saturating count of illegal selected accesses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err       <= 1'b0;
            r_err_count <= '0;
        end else if (w_illegal) begin
            r_err       <= 1'b1;
            r_err_count <= err_count_inc(r_err_count);
        end
    end

    assign err       = r_err;
    assign err_count = r_err_count;
`endif

endmodule : cpu_accel_endpoint

// File: tb/tb_cpu_accel_endpoint.sv
// Self-checking bench for cpu_accel_endpoint with ACCEL_ID=3, using a
// queue-based reference model of the two FIFOs and the id decode.
module tb_cpu_accel_endpoint;

    localparam int unsigned DW  = 16;
    localparam int unsigned IW  = 4;
    localparam int unsigned AID = 3;
    localparam int unsigned CD  = 4;
    localparam int unsigned RD  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [IW-1:0] accel_id;
    logic          accel_can_read;
    logic          accel_can_write;
    logic          accel_read_enable;
    logic [DW-1:0] accel_read_data;
    logic          accel_write_enable;
    logic [DW-1:0] accel_write_data;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [DW-1:0] cmd_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
`ifdef CPU_ACCEL_ENDPOINT_ERR_EN
    logic          err;
    logic [7:0]    err_count;
`endif

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] cmd_q[$];
    logic [DW-1:0] rsp_q[$];
    bit            m_err;
    int            m_err_cnt;

    cpu_accel_endpoint #(
        .DATA_WIDTH (DW),
        .ID_WIDTH   (IW),
        .ACCEL_ID   (AID),
        .CMD_DEPTH  (CD),
        .RSP_DEPTH  (RD)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .accel_id           (accel_id),
        .accel_can_read     (accel_can_read),
        .accel_can_write    (accel_can_write),
        .accel_read_enable  (accel_read_enable),
        .accel_read_data    (accel_read_data),
        .accel_write_enable (accel_write_enable),
        .accel_write_data   (accel_write_data),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_data           (cmd_data),
        .rsp_valid          (rsp_valid),
        .rsp_ready          (rsp_ready),
        .rsp_data           (rsp_data)
`ifdef CPU_ACCEL_ENDPOINT_ERR_EN
        ,
        .err                (err),
        .err_count          (err_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        cmd_q.delete();
        rsp_q.delete();
        m_err     = 1'b0;
        m_err_cnt = 0;
    endtask

    // Advance one clock edge, updating the reference model from the inputs seen at that edge
    task automatic tick();
        bit            sel;
        bit            c_push, c_pop, r_push, r_pop, ill;
        logic [DW-1:0] wd, rd;
        sel    = (accel_id == IW'(AID));
        c_push = accel_write_enable && sel && (cmd_q.size() < CD);
        c_pop  = cmd_ready && (cmd_q.size() > 0);
        r_push = rsp_valid && (rsp_q.size() < RD);
        r_pop  = accel_read_enable && sel && (rsp_q.size() > 0);
        ill    = sel && ((accel_read_enable && rsp_q.size() == 0) ||
                         (accel_write_enable && cmd_q.size() == CD));
        wd     = accel_write_data;
        rd     = rsp_data;
        @(posedge clk);
        if (c_pop)  void'(cmd_q.pop_front());
        if (c_push) cmd_q.push_back(wd);
        if (r_pop)  void'(rsp_q.pop_front());
        if (r_push) rsp_q.push_back(rd);
        if (ill) begin
            m_err = 1'b1;
            if (m_err_cnt < 255) m_err_cnt++;
        end
        #1;
    endtask

    task automatic idle_inputs();
        accel_id           = IW'(AID);
        accel_read_enable  = 1'b0;
        accel_write_enable = 1'b0;
        accel_write_data   = '0;
        cmd_ready          = 1'b0;
        rsp_valid          = 1'b0;
        rsp_data           = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        model_clear();
        #2;
        checks++; if (accel_can_write !== 1'b1) begin errors++; $display("FAIL reset_can_write got=%b exp=1", accel_can_write); end
        checks++; if (accel_can_read !== 1'b0) begin errors++; $display("FAIL reset_can_read got=%b exp=0", accel_can_read); end
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid got=%b exp=0", cmd_valid); end
        checks++; if (rsp_ready !== 1'b1) begin errors++; $display("FAIL reset_rsp_ready got=%b exp=1", rsp_ready); end
        checks++; if (accel_read_data !== 16'h0000) begin errors++; $display("FAIL reset_read_data got=%h exp=0000", accel_read_data); end
        checks++; if (cmd_data !== 16'h0000) begin errors++; $display("FAIL reset_cmd_data got=%h exp=0000", cmd_data); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_cmd_fill();
        logic [DW-1:0] words [5];
        words[0] = 16'h0011; words[1] = 16'h0022; words[2] = 16'h0033;
        words[3] = 16'h0044; words[4] = 16'h0055;
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            accel_write_enable = 1'b1;
            accel_write_data   = words[i];
            tick();
            if (i == 2) begin
                checks++; if (accel_can_write !== 1'b1) begin errors++; $display("FAIL fill_can_write_3 got=%b exp=1", accel_can_write); end
            end
            if (i >= 3) begin
                checks++; if (accel_can_write !== 1'b0) begin errors++; $display("FAIL fill_can_write_full%0d got=%b exp=0", i, accel_can_write); end
            end
        end
        accel_write_enable = 1'b0;
        cmd_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (cmd_valid !== 1'b1 || cmd_data !== words[i]) begin errors++; $display("FAIL fill_drain%0d got=%b/%h exp=1/%h", i, cmd_valid, cmd_data, words[i]); end
            tick();
        end
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL fill_drained_valid got=%b exp=0", cmd_valid); end
        cmd_ready = 1'b0;
    endtask

    task automatic test_rsp();
        idle_inputs();
        rsp_valid = 1'b1;
        rsp_data  = 16'h00AB;
        tick();
        rsp_data  = 16'h00CD;
        checks++; if (accel_can_read !== 1'b1 || accel_read_data !== 16'h00AB) begin errors++; $display("FAIL rsp_first got=%b/%h exp=1/00ab", accel_can_read, accel_read_data); end
        tick();
        rsp_valid = 1'b0;
        accel_read_enable = 1'b1;
        tick();
        checks++; if (accel_can_read !== 1'b1 || accel_read_data !== 16'h00CD) begin errors++; $display("FAIL rsp_second got=%b/%h exp=1/00cd", accel_can_read, accel_read_data); end
        tick();
        accel_read_enable = 1'b0;
        #1;
        checks++; if (accel_can_read !== 1'b0 || accel_read_data !== 16'h0000) begin errors++; $display("FAIL rsp_empty got=%b/%h exp=0/0000", accel_can_read, accel_read_data); end
    endtask

    task automatic test_deselect();
        idle_inputs();
        rsp_valid = 1'b1; rsp_data = 16'h1111;
        accel_write_enable = 1'b1; accel_write_data = 16'h0A0A;
        tick();
        rsp_data = 16'h2222; accel_write_data = 16'h0B0B;
        tick();
        idle_inputs();
        accel_id = 4'd5;
        #1;
        checks++; if (accel_can_read !== 1'b0 || accel_can_write !== 1'b0 || accel_read_data !== 16'h0000) begin errors++; $display("FAIL desel_outputs got=%b/%b/%h exp=0/0/0000", accel_can_read, accel_can_write, accel_read_data); end
        checks++; if (cmd_valid !== 1'b1 || rsp_ready !== 1'b1) begin errors++; $display("FAIL desel_core_side got=%b/%b exp=1/1", cmd_valid, rsp_ready); end
        accel_read_enable = 1'b1; accel_write_enable = 1'b1; accel_write_data = 16'h7777;
        tick();
        tick();
        idle_inputs();
        #1;
        checks++; if (accel_can_read !== 1'b1 || accel_read_data !== 16'h1111) begin errors++; $display("FAIL desel_rsp_kept got=%b/%h exp=1/1111", accel_can_read, accel_read_data); end
        checks++; if (cmd_data !== 16'h0A0A || accel_can_write !== 1'b1) begin errors++; $display("FAIL desel_cmd_kept got=%h/%b exp=0a0a/1", cmd_data, accel_can_write); end
        cmd_ready = 1'b1; accel_read_enable = 1'b1;
        tick();
        checks++; if (cmd_data !== 16'h0B0B || accel_read_data !== 16'h2222) begin errors++; $display("FAIL desel_second got=%h/%h exp=0b0b/2222", cmd_data, accel_read_data); end
        tick();
        idle_inputs();
        #1;
        checks++; if (cmd_valid !== 1'b0 || accel_can_read !== 1'b0) begin errors++; $display("FAIL desel_counts got=%b/%b exp=0/0", cmd_valid, accel_can_read); end
    endtask

    task automatic test_full_pushpop();
        logic [DW-1:0] tail [3];
        tail[0] = 16'h00A2; tail[1] = 16'h00A3; tail[2] = 16'h00A5;
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            accel_write_enable = 1'b1;
            accel_write_data   = DW'(16'h00A0 + i);
            tick();
        end
        checks++; if (accel_can_write !== 1'b0) begin errors++; $display("FAIL pp_full got=%b exp=0", accel_can_write); end
        cmd_ready = 1'b1; accel_write_data = 16'h00A4;
        tick();
        checks++; if (accel_can_write !== 1'b1 || cmd_data !== 16'h00A1) begin errors++; $display("FAIL pp_pop_on_full got=%b/%h exp=1/00a1", accel_can_write, cmd_data); end
        accel_write_data = 16'h00A5;
        tick();
        checks++; if (accel_can_write !== 1'b1 || cmd_q.size() != 3) begin errors++; $display("FAIL pp_same_cycle got=%b/%0d exp=1/3", accel_can_write, cmd_q.size()); end
        accel_write_enable = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (cmd_valid !== 1'b1 || cmd_data !== tail[i]) begin errors++; $display("FAIL pp_order%0d got=%b/%h exp=1/%h", i, cmd_valid, cmd_data, tail[i]); end
            tick();
        end
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL pp_drained got=%b exp=0", cmd_valid); end
        cmd_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [DW-1:0] exp_rd;
        bit            sel;
        for (int n = 0; n < 400; n++) begin
            accel_id           = ($urandom_range(0, 7) == 0) ? IW'(5) : IW'(AID);
            accel_write_enable = 1'($urandom_range(0, 1));
            accel_write_data   = DW'($urandom);
            accel_read_enable  = ($urandom_range(0, 9) < 4);
            cmd_ready          = (n < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            rsp_valid          = 1'($urandom_range(0, 1));
            rsp_data           = DW'($urandom);
            #1;
            sel    = (accel_id == IW'(AID));
            exp_rd = (sel && rsp_q.size() > 0) ? rsp_q[0] : '0;
            checks++; if (accel_can_write !== (sel && cmd_q.size() < CD)) begin errors++; $display("FAIL rnd_can_write n=%0d got=%b exp=%b", n, accel_can_write, (sel && cmd_q.size() < CD)); end
            checks++; if (accel_can_read !== (sel && rsp_q.size() > 0)) begin errors++; $display("FAIL rnd_can_read n=%0d got=%b exp=%b", n, accel_can_read, (sel && rsp_q.size() > 0)); end
            checks++; if (accel_read_data !== exp_rd) begin errors++; $display("FAIL rnd_read_data n=%0d got=%h exp=%h", n, accel_read_data, exp_rd); end
            checks++; if (cmd_valid !== (cmd_q.size() > 0)) begin errors++; $display("FAIL rnd_cmd_valid n=%0d got=%b exp=%b", n, cmd_valid, (cmd_q.size() > 0)); end
            if (cmd_q.size() > 0) begin
                checks++; if (cmd_data !== cmd_q[0]) begin errors++; $display("FAIL rnd_cmd_data n=%0d got=%h exp=%h", n, cmd_data, cmd_q[0]); end
            end
            checks++; if (rsp_ready !== (rsp_q.size() < RD)) begin errors++; $display("FAIL rnd_rsp_ready n=%0d got=%b exp=%b", n, rsp_ready, (rsp_q.size() < RD)); end
`ifdef CPU_ACCEL_ENDPOINT_ERR_EN
            checks++; if (err !== m_err || int'(err_count) != m_err_cnt) begin errors++; $display("FAIL rnd_err n=%0d got=%b/%0d exp=%b/%0d", n, err, err_count, m_err, m_err_cnt); end
`endif
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        cmd_ready = 1'b1;
        for (int i = 0; i < 8 && cmd_q.size() > 0; i++) tick();
        cmd_ready = 1'b0;
        accel_read_enable = 1'b1;
        for (int i = 0; i < 8 && rsp_q.size() > 0; i++) tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            accel_write_enable = 1'b1;
            accel_write_data   = DW'(16'h0C00 + i);
            tick();
        end
        accel_write_enable = 1'b0;
        checks++; if (cmd_valid !== 1'b1 || cmd_data !== 16'h0C00) begin errors++; $display("FAIL mid_before got=%b/%h exp=1/0c00", cmd_valid, cmd_data); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_clear();
        checks++; if (cmd_valid !== 1'b0 || cmd_data !== 16'h0000 || accel_can_write !== 1'b1) begin errors++; $display("FAIL mid_async got=%b/%h/%b exp=0/0000/1", cmd_valid, cmd_data, accel_can_write); end
        @(posedge clk);
        #1 rst = 1'b0;
        accel_write_enable = 1'b1;
        accel_write_data   = 16'hBEEF;
        tick();
        accel_write_enable = 1'b0;
        checks++; if (cmd_valid !== 1'b1 || cmd_data !== 16'hBEEF) begin errors++; $display("FAIL mid_first_after got=%b/%h exp=1/beef", cmd_valid, cmd_data); end
`ifdef CPU_ACCEL_ENDPOINT_ERR_EN
        checks++; if (err !== 1'b0 || err_count !== 8'd0) begin errors++; $display("FAIL err_cleared got=%b/%0d exp=0/0", err, err_count); end
        accel_read_enable = 1'b1;
        tick();
        accel_read_enable = 1'b0;
        checks++; if (err !== 1'b1 || err_count !== 8'd1) begin errors++; $display("FAIL err_read_empty got=%b/%0d exp=1/1", err, err_count); end
`endif
    endtask

    initial begin
        test_reset();
        test_cmd_fill();
        test_rsp();
        test_deselect();
        test_full_pushpop();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_cpu_accel_endpoint
